// File: rtl/vend_sequencer_pkg.sv
// Shared types, coin coding and payout helpers for the vending purchase sequencer.
// Coin codes are one-hot nibbles; any other nibble is an invalid coin.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CREDIT = 3'd1,
        ST_VEND   = 3'd2,
        ST_CHANGE = 3'd3,
        ST_ALARM  = 3'd4
    } vend_state_t;

    localparam logic [3:0] COIN_1  = 4'b0001;
    localparam logic [3:0] COIN_2  = 4'b0010;
    localparam logic [3:0] COIN_5  = 4'b0100;
    localparam logic [3:0] COIN_10 = 4'b1000;

    // Zero marks an invalid code, so callers can test validity on the value alone.
    function automatic logic [7:0] coin_value(input logic [3:0] code);
        logic [7:0] value;
        value = 8'd0;
        case (code)
            COIN_1:  value = 8'd1;
            COIN_2:  value = 8'd2;
            COIN_5:  value = 8'd5;
            COIN_10: value = 8'd10;
            default: value = 8'd0;
        endcase
        return value;
    endfunction

    // Largest denomination not exceeding the amount; 4'b0000 when nothing is owed.
    function automatic logic [3:0] greedy_coin(input logic [7:0] amount);
        logic [3:0] code;
        code = 4'b0000;
        if (amount >= 8'd10) begin
            code = COIN_10;
        end else if (amount >= 8'd5) begin
            code = COIN_5;
        end else if (amount >= 8'd2) begin
            code = COIN_2;
        end else if (amount >= 8'd1) begin
            code = COIN_1;
        end
        return code;
    endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Change-hopper handshake: the sequencer requests one coin at a time and the hopper acks it.
interface vend_sequencer_if;
    import vend_pkg::*;

    logic       change_req;
    logic [3:0] change_coin;
    logic [3:0] change_amount;
    logic       change_ack;

    modport master (
        output change_req,
        output change_coin,
        output change_amount,
        input  change_ack
    );

    modport slave (
        input  change_req,
        input  change_coin,
        input  change_amount,
        output change_ack
    );

endinterface

// File: rtl/vend_edge_detect.sv
// Registered rising-edge detector for one level button; emits a single-cycle pulse.
module vend_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= btn;
            pulse <= btn & ~prev;
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Purchase sequencer: coin credit, confirm/cancel handling, timed vend and alarm,
// and coin-by-coin change payout through the hopper handshake.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int DISPENSE_CYCLES = 4,
    parameter int ALARM_CYCLES    = 8,
    parameter int MAX_CREDIT      = 99
) (
    input  logic                    clk,
    input  logic                    reset_button,
    input  logic                    coin_insert_button,
    input  logic                    confirm_button,
    input  logic                    cancel_button,
    input  logic [3:0]              coin_code,
    input  logic [7:0]              product_price,
    vend_sequencer_if.master        chg,
    output logic [7:0]              credit,
    output logic                    product_dispensed,
    output logic                    alarm,
    output logic                    coin_reject,
    output logic [2:0]              state,
    output logic [7:0]              total_sales
);

    localparam logic [7:0] DISP_LOAD  = 8'(DISPENSE_CYCLES - 1);
    localparam logic [7:0] ALARM_LOAD = 8'(ALARM_CYCLES - 1);
    localparam logic [8:0] CREDIT_CAP = 9'(MAX_CREDIT);

    logic coin_edge;
    logic confirm_edge;
    logic cancel_edge;

    vend_edge_detect u_coin_edge (
        .clk   (clk),
        .rst   (reset_button),
        .btn   (coin_insert_button),
        .pulse (coin_edge)
    );

    vend_edge_detect u_confirm_edge (
        .clk   (clk),
        .rst   (reset_button),
        .btn   (confirm_button),
        .pulse (confirm_edge)
    );

    vend_edge_detect u_cancel_edge (
        .clk   (clk),
        .rst   (reset_button),
        .btn   (cancel_button),
        .pulse (cancel_edge)
    );

    vend_state_t state_q, state_n;
    logic [7:0]  credit_q, credit_n;
    logic [7:0]  change_q, change_n;
    logic [7:0]  price_q, price_n;
    logic [7:0]  cnt_q, cnt_n;
    logic [7:0]  total_q, total_n;
    logic        req_q, req_n;
    logic [3:0]  coin_q, coin_n;
    logic        disp_q, disp_n;
    logic        alarm_q, alarm_n;
    logic        reject_q, reject_n;

    logic [7:0]  insert_value;
    logic [8:0]  credit_sum;
    logic        busy;

    always_ff @(posedge clk) begin
        if (reset_button) begin
            state_q  <= ST_IDLE;
            credit_q <= 8'd0;
            change_q <= 8'd0;
            price_q  <= 8'd0;
            cnt_q    <= 8'd0;
            total_q  <= 8'd0;
            req_q    <= 1'b0;
            coin_q   <= 4'b0000;
            disp_q   <= 1'b0;
            alarm_q  <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            credit_q <= credit_n;
            change_q <= change_n;
            price_q  <= price_n;
            cnt_q    <= cnt_n;
            total_q  <= total_n;
            req_q    <= req_n;
            coin_q   <= coin_n;
            disp_q   <= disp_n;
            alarm_q  <= alarm_n;
            reject_q <= reject_n;
        end
    end

    // Cancel outranks a coin, and a coin outranks a confirm arriving in the same cycle.
    always_comb begin
        state_n      = state_q;
        credit_n     = credit_q;
        change_n     = change_q;
        price_n      = price_q;
        cnt_n        = cnt_q;
        total_n      = total_q;
        req_n        = req_q;
        coin_n       = coin_q;
        disp_n       = disp_q;
        alarm_n      = alarm_q;
        reject_n     = 1'b0;
        insert_value = coin_value(coin_code);
        credit_sum   = {1'b0, credit_q} + {1'b0, insert_value};
        busy         = (state_q == ST_VEND) || (state_q == ST_CHANGE) || (state_q == ST_ALARM);

        if (busy && coin_edge) begin
            reject_n = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (cancel_edge && (state_q == ST_CREDIT)) begin
                    change_n = credit_q;
                    credit_n = 8'd0;
                    state_n  = ST_CHANGE;
                    req_n    = (credit_q != 8'd0);
                    coin_n   = greedy_coin(credit_q);
                end else if (coin_edge) begin
                    if ((insert_value != 8'd0) && (credit_sum <= CREDIT_CAP)) begin
                        credit_n = credit_sum[7:0];
                        state_n  = ST_CREDIT;
                    end else begin
                        reject_n = 1'b1;
                    end
                end else if (confirm_edge) begin
                    if (state_q == ST_CREDIT) begin
                        price_n = product_price;
                    end
                    if ((state_q == ST_CREDIT) && (price_n != 8'd0) && (credit_q >= price_n)) begin
                        total_n  = total_q + price_n;
                        change_n = credit_q - price_n;
                        credit_n = 8'd0;
                        disp_n   = 1'b1;
                        cnt_n    = DISP_LOAD;
                        state_n  = ST_VEND;
                    end else begin
                        alarm_n = 1'b1;
                        cnt_n   = ALARM_LOAD;
                        state_n = ST_ALARM;
                    end
                end
            end

            ST_VEND: begin
                if (cnt_q == 8'd0) begin
                    disp_n = 1'b0;
                    if (change_q != 8'd0) begin
                        req_n   = 1'b1;
                        coin_n  = greedy_coin(change_q);
                        state_n = ST_CHANGE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt_q - 8'd1;
                end
            end

            // The request drops for one cycle after each ack before the next coin is offered.
            ST_CHANGE: begin
                if (req_q) begin
                    if (chg.change_ack) begin
                        change_n = change_q - coin_value(coin_q);
                        req_n    = 1'b0;
                        coin_n   = 4'b0000;
                        if (change_n == 8'd0) begin
                            state_n = ST_IDLE;
                        end
                    end
                end else if (change_q != 8'd0) begin
                    req_n  = 1'b1;
                    coin_n = greedy_coin(change_q);
                end else begin
                    state_n = ST_IDLE;
                end
            end

            ST_ALARM: begin
                if (cnt_q == 8'd0) begin
                    alarm_n = 1'b0;
                    state_n = (credit_q != 8'd0) ? ST_CREDIT : ST_IDLE;
                end else begin
                    cnt_n = cnt_q - 8'd1;
                end
            end

            default: begin
                state_n = ST_IDLE;
                req_n   = 1'b0;
                coin_n  = 4'b0000;
                disp_n  = 1'b0;
                alarm_n = 1'b0;
            end
        endcase
    end

    assign chg.change_req    = req_q;
    assign chg.change_coin   = coin_q;
    assign chg.change_amount = change_q[3:0];
    assign credit            = credit_q;
    assign product_dispensed = disp_q;
    assign alarm             = alarm_q;
    assign coin_reject       = reject_q;
    assign state             = state_q;
    assign total_sales       = total_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer: purchase, alarm, rejects, cancel payout,
// same-cycle coin/confirm, held confirm and reset during payout.
module tb_vend_sequencer;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       reset_button = 1'b0;
    logic       coin_insert_button = 1'b0;
    logic       confirm_button = 1'b0;
    logic       cancel_button = 1'b0;
    logic [3:0] coin_code = 4'b0000;
    logic [7:0] product_price = 8'd0;
    logic [7:0] credit;
    logic       product_dispensed;
    logic       alarm;
    logic       coin_reject;
    logic [2:0] state;
    logic [7:0] total_sales;

    int checks = 0;
    int failures = 0;

    vend_sequencer_if chg_if ();

    vend_sequencer #(
        .DISPENSE_CYCLES (4),
        .ALARM_CYCLES    (8),
        .MAX_CREDIT      (99)
    ) dut (
        .clk                (clk),
        .reset_button       (reset_button),
        .coin_insert_button (coin_insert_button),
        .confirm_button     (confirm_button),
        .cancel_button      (cancel_button),
        .coin_code          (coin_code),
        .product_price      (product_price),
        .chg                (chg_if),
        .credit             (credit),
        .product_dispensed  (product_dispensed),
        .alarm              (alarm),
        .coin_reject        (coin_reject),
        .state              (state),
        .total_sales        (total_sales)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One-cycle press of the selected buttons; results are visible when this returns.
    task automatic applyStimulus(input logic [3:0] code, input logic coin, input logic confirm, input logic cancel);
        coin_code          = code;
        coin_insert_button = coin;
        confirm_button     = confirm;
        cancel_button      = cancel;
        tick();
        coin_insert_button = 1'b0;
        confirm_button     = 1'b0;
        cancel_button      = 1'b0;
        tick();
    endtask

    function automatic int coin_units(input logic [3:0] code);
        case (code)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 5;
            4'b1000: return 10;
            default: return 0;
        endcase
    endfunction

    initial begin
        logic [3:0] exp_coins [4];
        logic [7:0] exp_remain [4];
        int paid_sum;
        int paid_count;
        logic drained;

        chg_if.change_ack = 1'b0;

        reset_button = 1'b1;
        tick();
        checkOutput("rst_state", state, 0);
        checkOutput("rst_credit", credit, 0);
        checkOutput("rst_req", chg_if.change_req, 0);
        checkOutput("rst_coin", chg_if.change_coin, 0);
        checkOutput("rst_amount", chg_if.change_amount, 0);
        checkOutput("rst_disp", product_dispensed, 0);
        checkOutput("rst_alarm", alarm, 0);
        checkOutput("rst_reject", coin_reject, 0);
        checkOutput("rst_total", total_sales, 0);
        tick();
        reset_button = 1'b0;
        tick();

        $display("[TB] purchase 25 credit, price 20");
        product_price = 8'd20;
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        checkOutput("buy_credit10", credit, 10);
        checkOutput("buy_state_credit", state, 1);
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        checkOutput("buy_credit25", credit, 25);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("buy_state_vend", state, 2);
        checkOutput("buy_total", total_sales, 20);
        checkOutput("buy_credit_cleared", credit, 0);
        checkOutput("buy_change_amount", chg_if.change_amount, 5);
        for (int i = 0; i < 4; i++) begin
            checkOutput("buy_disp_high", product_dispensed, 1);
            tick();
        end
        checkOutput("buy_disp_low", product_dispensed, 0);
        checkOutput("buy_state_change", state, 3);
        checkOutput("buy_req", chg_if.change_req, 1);
        checkOutput("buy_coin5", chg_if.change_coin, 4'b0100);
        chg_if.change_ack = 1'b1;
        tick();
        chg_if.change_ack = 1'b0;
        checkOutput("buy_req_done", chg_if.change_req, 0);
        checkOutput("buy_state_idle", state, 0);
        checkOutput("buy_amount_done", chg_if.change_amount, 0);

        $display("[TB] insufficient credit alarm");
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        checkOutput("alm_credit3", credit, 3);
        product_price = 8'd7;
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("alm_state", state, 4);
        for (int i = 0; i < 8; i++) begin
            checkOutput("alm_high", alarm, 1);
            tick();
        end
        checkOutput("alm_low", alarm, 0);
        checkOutput("alm_state_credit", state, 1);
        checkOutput("alm_credit_kept", credit, 3);

        $display("[TB] credit ceiling and invalid code");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        checkOutput("cap_credit95", credit, 95);
        checkOutput("cap_no_reject", coin_reject, 0);
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        checkOutput("cap_reject", coin_reject, 1);
        checkOutput("cap_credit_kept", credit, 95);
        tick();
        checkOutput("cap_reject_pulse", coin_reject, 0);
        applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0);
        checkOutput("bad_reject", coin_reject, 1);
        checkOutput("bad_credit_kept", credit, 95);

        $display("[TB] cancel 95 and drain");
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput("c95_state", state, 3);
        checkOutput("c95_credit", credit, 0);
        checkOutput("c95_amount", chg_if.change_amount, 4'hF);
        checkOutput("c95_coin", chg_if.change_coin, 4'b1000);
        paid_sum = 0;
        paid_count = 0;
        drained = 1'b0;
        for (int i = 0; i < 100 && !drained; i++) begin
            if (state == 3'd0) begin
                drained = 1'b1;
            end else if (chg_if.change_req) begin
                paid_sum += coin_units(chg_if.change_coin);
                paid_count++;
                chg_if.change_ack = 1'b1;
                tick();
                chg_if.change_ack = 1'b0;
            end else begin
                tick();
            end
        end
        checkOutput("c95_drained", drained, 1);
        checkOutput("c95_sum", paid_sum, 95);
        checkOutput("c95_count", paid_count, 10);

        $display("[TB] cancel 18 with delayed ack");
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        checkOutput("c18_credit", credit, 18);
        exp_coins  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        exp_remain = '{8'd18, 8'd8, 8'd3, 8'd1};
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("c18_amount", chg_if.change_amount, exp_remain[k][3:0]);
            for (int d = 0; d < 3; d++) begin
                checkOutput("c18_req_held", chg_if.change_req, 1);
                checkOutput("c18_coin", chg_if.change_coin, exp_coins[k]);
                tick();
            end
            chg_if.change_ack = 1'b1;
            tick();
            chg_if.change_ack = 1'b0;
            checkOutput("c18_req_gap", chg_if.change_req, 0);
            if (k < 3) begin
                checkOutput("c18_state_change", state, 3);
                tick();
            end
        end
        checkOutput("c18_state_idle", state, 0);

        $display("[TB] coin and confirm in the same cycle");
        product_price = 8'd1;
        applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0);
        checkOutput("same_credit", credit, 2);
        checkOutput("same_state", state, 1);
        checkOutput("same_no_disp", product_dispensed, 0);
        tick();
        checkOutput("same_state_stays", state, 1);

        $display("[TB] held confirm");
        confirm_button = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        checkOutput("held_total", total_sales, 21);
        checkOutput("held_state", state, 3);
        checkOutput("held_coin", chg_if.change_coin, 4'b0001);
        confirm_button = 1'b0;
        tick();
        chg_if.change_ack = 1'b1;
        tick();
        chg_if.change_ack = 1'b0;
        tick();
        tick();
        checkOutput("held_idle", state, 0);
        checkOutput("held_total_once", total_sales, 21);
        checkOutput("held_no_alarm", alarm, 0);

        $display("[TB] confirm with no credit");
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_cfm_alarm", alarm, 1);
        checkOutput("idle_cfm_state", state, 4);
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        checkOutput("idle_cfm_back", state, 0);

        $display("[TB] reset during payout");
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput("mid_state_change", state, 3);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        checkOutput("mid_busy_reject", coin_reject, 1);
        checkOutput("mid_busy_credit", credit, 0);
        reset_button = 1'b1;
        tick();
        reset_button = 1'b0;
        checkOutput("mid_rst_state", state, 0);
        checkOutput("mid_rst_req", chg_if.change_req, 0);
        checkOutput("mid_rst_coin", chg_if.change_coin, 0);
        checkOutput("mid_rst_amount", chg_if.change_amount, 0);
        checkOutput("mid_rst_total", total_sales, 0);
        checkOutput("mid_rst_disp", product_dispensed, 0);
        checkOutput("mid_rst_credit", credit, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
